// File: rtl/mem_bridge.sv
// Core-to-asynchronous-SRAM bridge: one byte access per core clock-enable pulse, with bus hold.
// Optional ROM write protection of the top 64 KiB when MEM_BRIDGE_ROMWP_EN is defined.
module mem_bridge #(
    parameter int unsigned WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        ce,
    input  logic        hold,
    output logic        hold_ack,
    output logic [19:0] sram_a,
    output logic [7:0]  sram_do,
    input  logic [7:0]  sram_di,
    output logic        sram_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] rdata_nxt;
    logic          ce_nxt;
    logic          hold_ack_nxt;
    logic [AW-1:0] sram_a_nxt;
    logic [DW-1:0] sram_do_nxt;
    logic          sram_oe_nxt, sram_ce_n_nxt, sram_oe_n_nxt, sram_we_n_nxt;
    logic          lat_we, lat_we_nxt;
    logic          wp_c;

    // Write-protect decode on the incoming address; only used when latching a write.
`ifdef MEM_BRIDGE_ROMWP_EN
    assign wp_c = (address[19:16] == 4'hF);
`else
    assign wp_c = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata     <= '0;
            ce        <= 1'b0;
            hold_ack  <= 1'b0;
            sram_a    <= '0;
            sram_do   <= '0;
            sram_oe   <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            lat_we    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rdata     <= rdata_nxt;
            ce        <= ce_nxt;
            hold_ack  <= hold_ack_nxt;
            sram_a    <= sram_a_nxt;
            sram_do   <= sram_do_nxt;
            sram_oe   <= sram_oe_nxt;
            sram_ce_n <= sram_ce_n_nxt;
            sram_oe_n <= sram_oe_n_nxt;
            sram_we_n <= sram_we_n_nxt;
            lat_we    <= lat_we_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rdata_nxt     = rdata;
        ce_nxt        = 1'b0;
        hold_ack_nxt  = hold_ack;
        sram_a_nxt    = sram_a;
        sram_do_nxt   = sram_do;
        sram_oe_nxt   = sram_oe;
        sram_ce_n_nxt = sram_ce_n;
        sram_oe_n_nxt = sram_oe_n;
        sram_we_n_nxt = sram_we_n;
        lat_we_nxt    = lat_we;

        case (state)
            IDLE: begin
                if (hold) begin
                    hold_ack_nxt  = 1'b1;
                    sram_ce_n_nxt = 1'b1;
                    sram_oe_n_nxt = 1'b1;
                    sram_we_n_nxt = 1'b1;
                    sram_oe_nxt   = 1'b0;
                end else begin
                    hold_ack_nxt  = 1'b0;
                    sram_a_nxt    = address;
                    sram_do_nxt   = wdata;
                    lat_we_nxt    = we;
                    cnt_nxt       = CW'(WAIT);
                    sram_ce_n_nxt = 1'b0;
                    if (we) begin
                        // Protected writes keep full timing but never strobe the SRAM.
                        if (!wp_c) begin
                            sram_we_n_nxt = 1'b0;
                            sram_oe_nxt   = 1'b1;
                        end
                    end else begin
                        sram_oe_n_nxt = 1'b0;
                    end
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    rdata_nxt     = lat_we ? sram_do : sram_di;
                    sram_ce_n_nxt = 1'b1;
                    sram_oe_n_nxt = 1'b1;
                    sram_we_n_nxt = 1'b1;
                    sram_oe_nxt   = 1'b0;
                    ce_nxt        = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
